// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer and its activation block.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DATA_W_DEF    = 16;
  localparam int ACC_W_DEF     = 32;
  localparam int FRAC_BITS_DEF = 8;

  localparam logic signed [15:0] SAT_MAX_DEF = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN_DEF = 16'sh8000;

  // Address width that stays at least one bit for single-entry memories.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_act_sat.sv
// Rescale, saturate and activate one accumulator value.
// Optional ReLU selected by macro MLP_SEQ_RELU_EN.
module mlp_act_sat
  import mlp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > MAX_V) begin
      sat = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef MLP_SEQ_RELU_EN
    if (sat[DATA_W-1]) begin
      res = '0;
    end else begin
      res = sat;
    end
`else
    res = sat;
`endif
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one fully-connected layer over an external MAC, memories and output buffer.
// Activation is linear unless macro MLP_SEQ_RELU_EN is defined (see mlp_act_sat).
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  localparam int XW = addr_w(N_IN),
  localparam int WW = addr_w(N_IN * N_OUT),
  localparam int OW = addr_w(N_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              finished,
  output logic [XW-1:0]     x_addr,
  output logic [WW-1:0]     w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_we,
  output logic [OW-1:0]     out_addr,
  output logic [DATA_W-1:0] out
);

  state_t state, next_state;

  logic              last_i;
  logic              last_j;
  logic [WW-1:0]     w_base;
  logic [DATA_W-1:0] act_val;
  logic [DATA_W-1:0] out_hold;

  // x_addr doubles as the input index and out_addr as the neuron index
  assign last_i = (x_addr == XW'(N_IN - 1));
  assign last_j = (out_addr == OW'(N_OUT - 1));
  assign w_base = WW'(out_addr * N_IN);

  mlp_act_sat #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_act (
    .acc (mac_acc),
    .res (act_val)
  );

  // The live activation is visible during the write strobe, then held.
  assign out = out_we ? act_val : out_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
               else       next_state = IDLE;
      CLEAR:   next_state = ISSUE;
      ISSUE:   if (last_i) next_state = DRAIN;
               else        next_state = ISSUE;
      DRAIN:   next_state = WRITE;
      WRITE:   if (last_j) next_state = DONE;
               else        next_state = CLEAR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      finished <= 1'b0;
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      out_we   <= 1'b0;
      x_addr   <= '0;
      w_addr   <= '0;
      out_addr <= '0;
      out_hold <= '0;
    end else begin
      busy    <= (next_state != IDLE);
      mac_clr <= (next_state == CLEAR);
      mac_en  <= (state == ISSUE);
      out_we  <= (next_state == WRITE);
      if (state == IDLE && start) begin
        finished <= 1'b0;
      end else if (next_state == DONE) begin
        finished <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) out_addr <= '0;
        end
        CLEAR: begin
          x_addr <= '0;
          w_addr <= w_base;
        end
        ISSUE: begin
          if (!last_i) begin
            x_addr <= x_addr + XW'(1);
            w_addr <= w_addr + WW'(1);
          end
        end
        WRITE: begin
          out_hold <= act_val;
          if (!last_j) out_addr <= out_addr + OW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench: emulated memories/MAC plus an arithmetic reference of the layer.
module tb_mlp_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, finished, mac_clr, mac_en, out_we;
  logic [1:0]  x_addr, out_addr;
  logic [3:0]  w_addr;
  logic [31:0] mac_acc;
  logic [15:0] out;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] xm [4];
  logic signed [15:0] wm [16];
  logic signed [15:0] xq, wq;
  logic [31:0] acc_m;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic [15:0] exp_hold = 16'h0;
  logic [15:0] first_write_out;

  always #5 clk = ~clk;

  mlp_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
    .x_addr(x_addr), .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_acc(mac_acc), .out_we(out_we), .out_addr(out_addr), .out(out)
  );

  // Environment: 1-cycle-latency memories feeding a registered MAC
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_m <= 32'h0; xq <= 16'sh0; wq <= 16'sh0;
    end else begin
      xq <= xm[x_addr];
      wq <= wm[w_addr];
      if (mac_clr) acc_m <= 32'h0;
      else if (mac_en) acc_m <= acc_m + 32'(longint'(xq) * longint'(wq));
    end
  end
  assign mac_acc = force_en ? force_val : acc_m;

  function automatic logic [15:0] act_ref(input logic [31:0] a);
    longint s;
    s = longint'($signed(a));
    s = s >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef MLP_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  function automatic logic [15:0] neuron_ref(input int j);
    longint sum = 0;
    for (int i = 0; i < 4; i++) sum += longint'(xm[i]) * longint'(wm[j*4+i]);
    return act_ref(32'(sum));
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 20; i++) begin
      int v;
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535)) - 32768;
      else v = int'($urandom_range(0, 4095)) - 2048;
      if (i < 4) xm[i] = 16'(v); else wm[i-4] = 16'(v);
    end
  endtask

  // One layer pass from a start at edge 0, checked cycle by cycle.
  task automatic run_pass(input bit forced, input logic [31:0] fv, input int pulse_at, input int reset_at);
    force_en = forced; force_val = fv;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      int k = c % 7;
      int nj = c / 7;
      logic [4:0] e_ctl, a_ctl;
      e_ctl = {c <= 29, c >= 29, (k == 1 && c <= 22), (k >= 3 && c < 29), (k == 0 && c <= 28)};
      a_ctl = {busy, finished, mac_clr, mac_en, out_we};
      if (e_ctl[0]) exp_hold = forced ? act_ref(fv) : neuron_ref(nj - 1);
      tests++;
      if (a_ctl !== e_ctl) begin
        fails++;
        $display("FAIL ctl cycle %0d: busy,fin,clr,en,we got %b want %b", c, a_ctl, e_ctl);
      end
      tests++;
      if (out !== exp_hold) begin
        fails++;
        $display("FAIL out cycle %0d: got %h want %h", c, out, exp_hold);
      end
      if (e_ctl[0]) begin
        tests++;
        if (out_addr !== 2'(nj - 1)) begin
          fails++;
          $display("FAIL out_addr cycle %0d: got %0d want %0d", c, out_addr, nj - 1);
        end
      end
      if (c >= 2 && c <= 28 && k != 1) begin
        int e_x = (k >= 2 && k <= 5) ? k - 2 : 3;
        int e_n = (k == 0) ? nj - 1 : nj;
        tests++;
        if (x_addr !== 2'(e_x) || w_addr !== 4'(e_n * 4 + e_x)) begin
          fails++;
          $display("FAIL addr cycle %0d: x %0d w %0d want x %0d w %0d", c, x_addr, w_addr, e_x, e_n*4+e_x);
        end
      end
      if (c == 7) first_write_out = out;
      start = (c == pulse_at);
      if (c == reset_at) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, finished, mac_clr, mac_en, out_we, x_addr, w_addr, out_addr, out} !== 29'h0) begin
          fails++;
          $display("FAIL async_reset: outputs %b %b %b %b %b %h %h %h %h want all 0",
                   busy, finished, mac_clr, mac_en, out_we, x_addr, w_addr, out_addr, out);
        end
        @(negedge clk); reset = 1'b0;
        exp_hold = 16'h0;
        for (int q = 0; q < 20; q++) begin
          @(negedge clk);
          tests++;
          if (out_we !== 1'b0 || busy !== 1'b0 || out !== 16'h0) begin
            fails++;
            $display("FAIL post_reset_idle %0d: we %b busy %b out %h want 0 0 0", q, out_we, busy, out);
          end
        end
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, finished, mac_clr, mac_en, out_we, x_addr, w_addr, out_addr, out} !== 29'h0) begin
      fails++;
      $display("FAIL reset_state: got %b%b%b%b%b %h %h %h %h want all 0",
               busy, finished, mac_clr, mac_en, out_we, x_addr, w_addr, out_addr, out);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mac_clr !== 1'b0 || finished !== 1'b0) begin
      fails++;
      $display("FAIL reset_beats_start: busy %b clr %b fin %b want 0 0 0", busy, mac_clr, finished);
    end
    exp_hold = 16'h0;
  endtask

  task automatic test_random_pass();
    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      run_pass(1'b0, 32'h0, -1, -1);
    end
  endtask

  task automatic test_arith();
    logic [31:0] accs [2] = '{32'h0000_0380, 32'h0100_0000};
    logic [15:0] outs [2] = '{16'h0003, 16'h7FFF};
    for (int t = 0; t < 2; t++) begin
      run_pass(1'b1, accs[t], -1, -1);
      tests++;
      if (first_write_out !== outs[t]) begin
        fails++;
        $display("FAIL arith acc %h: out %h want %h", accs[t], first_write_out, outs[t]);
      end
    end
  endtask

  task automatic test_activation();
    logic [31:0] accs [2] = '{32'hFFFF_FE00, 32'h8000_0000};
`ifdef MLP_SEQ_RELU_EN
    logic [15:0] outs [2] = '{16'h0000, 16'h0000};
`else
    logic [15:0] outs [2] = '{16'hFFFE, 16'h8000};
`endif
    for (int t = 0; t < 2; t++) begin
      run_pass(1'b1, accs[t], -1, -1);
      tests++;
      if (first_write_out !== outs[t]) begin
        fails++;
        $display("FAIL activation acc %h: out %h want %h", accs[t], first_write_out, outs[t]);
      end
    end
  endtask

  task automatic test_start_mid();
    randomize_mem();
    run_pass(1'b0, 32'h0, 10, -1);
  endtask

  task automatic test_reset_mid();
    randomize_mem();
    run_pass(1'b0, 32'h0, -1, 16);
  endtask

  task automatic test_back_to_back();
    randomize_mem();
    run_pass(1'b0, 32'h0, -1, -1);
    randomize_mem();
    run_pass(1'b0, 32'h0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_random_pass();
    test_arith();
    test_activation();
    test_start_mid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
